// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the 3x3 convolution engine.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT,
        FIN
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;

    // Working width for the post-accumulation helper; covers any ACC_W this engine produces.
    localparam int SAT_W = 64;

    function automatic int acc_width(input int cin, input int data_w = DATA_W_DEF);
        return 2 * data_w + $clog2(9 * cin);
    endfunction

    // Drop the fractional bits of the product scale, clamp to the signed data range,
    // then clamp negatives to zero (ReLU).
    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] acc,
        input int                      data_w,
        input int                      frac_w
    );
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] max_pos;
        shifted = acc >>> frac_w;
        max_pos = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
        if (shifted < 0) begin
            return '0;
        end
        if (shifted > max_pos) begin
            return max_pos;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/conv_mac_pipe.sv
// Registered multiply followed by accumulate; taps flagged invalid (padding) add nothing.
module conv_mac_pipe
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = acc_width(256)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              tap_vld,
    input  logic [DATA_W-1:0] ifm_data,
    input  logic [DATA_W-1:0] ker_data,
    output logic [ACC_W-1:0]  acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic                     vld_p1;
    logic                     vld_p2;
    logic signed [PROD_W-1:0] prod_p2;
    logic signed [ACC_W-1:0]  acc_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            prod_p2 <= '0;
            acc_p3  <= '0;
        end else begin
            // p0 -> p1: read data lands one cycle after the strobe
            vld_p1  <= tap_vld;
            // p1 -> p2: product of the returned operands
            prod_p2 <= PROD_W'($signed(ifm_data)) * PROD_W'($signed(ker_data));
            vld_p2  <= vld_p1;
            // p2 -> p3: accumulate
            if (clr) begin
                acc_p3 <= '0;
            end else if (vld_p2) begin
                acc_p3 <= acc_p3 + ACC_W'(prod_p2);
            end
        end
    end

    assign acc = acc_p3;

endmodule

// File: rtl/conv3x3_relu_engine.sv
// Serial 3x3 stride-1 zero-padded convolution with fused ReLU, one tap per cycle.
// Optional per-output-channel bias is enabled by defining CONV_BIAS_EN.
module conv3x3_relu_engine
    import conv_pkg::*;
#(
    parameter int H       = 13,
    parameter int W       = 13,
    parameter int CIN     = 256,
    parameter int COUT    = 384,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    localparam int IFM_AW = (H * W * CIN > 1) ? $clog2(H * W * CIN) : 1,
    localparam int KER_AW = $clog2(COUT * 9 * CIN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ifm_rd_en,
    output logic [IFM_AW-1:0] ifm_rd_addr,
    input  logic [DATA_W-1:0] ifm_rd_data,
    output logic              ker_rd_en,
    output logic [KER_AW-1:0] ker_rd_addr,
    input  logic [DATA_W-1:0] ker_rd_data,
`ifdef CONV_BIAS_EN
    output logic                                        bias_rd_en,
    output logic [((COUT > 1) ? $clog2(COUT) : 1)-1:0] bias_rd_addr,
    input  logic [DATA_W-1:0]                           bias_rd_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int ACC_W = acc_width(CIN, DATA_W);
    localparam int CI_W  = (CIN > 1)  ? $clog2(CIN)  : 1;
    localparam int CO_W  = (COUT > 1) ? $clog2(COUT) : 1;
    localparam int X_W   = (W > 1)    ? $clog2(W)    : 1;
    localparam int Y_W   = (H > 1)    ? $clog2(H)    : 1;

    state_t state;
    state_t state_nxt;

    logic [CI_W-1:0] ci;
    logic [1:0]      kx;
    logic [1:0]      ky;
    logic [1:0]      drain_cnt;
    logic [CO_W-1:0] co;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;

    logic start_acc;
    logic tap_last;
    logic drain_last;
    logic pix_last;
    logic hs;
    logic mac_clr;
    logic tap_inside;
    int   iy;
    int   ix;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_total;

    assign start_acc  = (state == IDLE) && start;
    assign tap_last   = (ci == CI_W'(CIN - 1)) && (kx == 2'd2) && (ky == 2'd2);
    assign drain_last = (drain_cnt == 2'd2);
    assign pix_last   = (co == CO_W'(COUT - 1)) && (x == X_W'(W - 1)) && (y == Y_W'(H - 1));
    assign hs         = (state == OUT) && out_ready;
    assign mac_clr    = start_acc || hs;

    // Source pixel of the current tap; outside the map it is a zero-padding tap.
    always_comb begin
        iy         = int'(y) + int'(ky) - 1;
        ix         = int'(x) + int'(kx) - 1;
        tap_inside = (iy >= 0) && (iy < H) && (ix >= 0) && (ix < W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = MAC;
            MAC:     if (tap_last)   state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = OUT;
            OUT:     if (out_ready)  state_nxt = pix_last ? FIN : MAC;
            FIN:                     state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        ifm_rd_en   = 1'b0;
        ker_rd_en   = 1'b0;
        ifm_rd_addr = '0;
        ker_rd_addr = '0;
`ifdef CONV_BIAS_EN
        bias_rd_en   = 1'b0;
        bias_rd_addr = '0;
`endif
        case (state)
            MAC: begin
                busy      = 1'b1;
                ifm_rd_en = tap_inside;
                ker_rd_en = tap_inside;
                if (tap_inside) begin
                    ifm_rd_addr = IFM_AW'((iy * W + ix) * CIN + int'(ci));
                    ker_rd_addr = KER_AW'(((int'(co) * 3 + int'(ky)) * 3 + int'(kx)) * CIN + int'(ci));
                end
`ifdef CONV_BIAS_EN
                if ((ci == '0) && (kx == 2'd0) && (ky == 2'd0)) begin
                    bias_rd_en   = 1'b1;
                    bias_rd_addr = co;
                end
`endif
            end
            DRAIN: busy = 1'b1;
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = pix_last;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // Tap counters (ci fastest, then kx, then ky) and output counters (co, x, y).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ci        <= '0;
            kx        <= '0;
            ky        <= '0;
            drain_cnt <= '0;
            co        <= '0;
            x         <= '0;
            y         <= '0;
        end else if (start_acc) begin
            ci        <= '0;
            kx        <= '0;
            ky        <= '0;
            drain_cnt <= '0;
            co        <= '0;
            x         <= '0;
            y         <= '0;
        end else begin
            if (state == MAC) begin
                if (ci == CI_W'(CIN - 1)) begin
                    ci <= '0;
                    if (kx == 2'd2) begin
                        kx <= '0;
                        ky <= (ky == 2'd2) ? 2'd0 : ky + 2'd1;
                    end else begin
                        kx <= kx + 2'd1;
                    end
                end else begin
                    ci <= ci + 1'b1;
                end
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_last ? 2'd0 : drain_cnt + 2'd1;
            end
            if (hs) begin
                if (co == CO_W'(COUT - 1)) begin
                    co <= '0;
                    if (x == X_W'(W - 1)) begin
                        x <= '0;
                        y <= (y == Y_W'(H - 1)) ? '0 : y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end else begin
                    co <= co + 1'b1;
                end
            end
        end
    end

    conv_mac_pipe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (mac_clr),
        .tap_vld  (ifm_rd_en),
        .ifm_data (ifm_rd_data),
        .ker_data (ker_rd_data),
        .acc      (acc)
    );

`ifdef CONV_BIAS_EN
    logic                    bias_vld_p1;
    logic signed [ACC_W-1:0] bias_acc;

    // Bias is aligned to the product scale (2*FRAC_W fractional bits) before joining the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_vld_p1 <= 1'b0;
            bias_acc    <= '0;
        end else begin
            bias_vld_p1 <= bias_rd_en;
            if (mac_clr) begin
                bias_acc <= '0;
            end else if (bias_vld_p1) begin
                bias_acc <= ACC_W'($signed(bias_rd_data)) <<< FRAC_W;
            end
        end
    end

    assign acc_total = acc + bias_acc;
`else
    assign acc_total = acc;
`endif

    // The last drain cycle is the first one in which the final accumulate is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if ((state == DRAIN) && drain_last) begin
            out_data <= DATA_W'(sat_relu(SAT_W'(acc_total), DATA_W, FRAC_W));
        end
    end

endmodule

// File: tb/tb_conv3x3_relu_engine.sv
// Scoreboard bench: two engine instances (3x3x1->1 and 2x2x1->2) against hand-computed outputs.
module tb_conv3x3_relu_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance A: H=W=3, CIN=1, COUT=1 ----------------
    logic        start_a, busy_a, done_a, ifm_en_a, ker_en_a, ov_a, or_a, ol_a;
    logic [3:0]  ifm_addr_a, ker_addr_a;
    logic [15:0] ifm_data_a = '0, ker_data_a = '0, od_a;
    logic [15:0] ifm_mem_a [9];
    logic [15:0] ker_mem_a [9];
    logic [16:0] q_a [$];
    int          rd_ifm_a = 0, rd_ker_a = 0, bad_a = 0, done_cnt_a = 0;
`ifdef CONV_BIAS_EN
    logic        bias_en_a, bias_en_b;
    logic [0:0]  bias_addr_a, bias_addr_b;
    logic [15:0] bias_data_a = '0, bias_data_b = '0;
`endif

    conv3x3_relu_engine #(.H(3), .W(3), .CIN(1), .COUT(1), .DATA_W(16), .FRAC_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .ifm_rd_en(ifm_en_a), .ifm_rd_addr(ifm_addr_a), .ifm_rd_data(ifm_data_a),
        .ker_rd_en(ker_en_a), .ker_rd_addr(ker_addr_a), .ker_rd_data(ker_data_a),
`ifdef CONV_BIAS_EN
        .bias_rd_en(bias_en_a), .bias_rd_addr(bias_addr_a), .bias_rd_data(bias_data_a),
`endif
        .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .out_last(ol_a)
    );

    always @(posedge clk) begin
        if (ifm_en_a) begin
            ifm_data_a <= ifm_mem_a[ifm_addr_a];
            rd_ifm_a++;
            if (ifm_addr_a >= 4'd9) bad_a++;
        end
        if (ker_en_a) begin
            ker_data_a <= ker_mem_a[ker_addr_a];
            rd_ker_a++;
            if (ker_addr_a >= 4'd9) bad_a++;
        end
    end

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (ov_a && or_a) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected_output: got %0h, expected none", od_a);
            end else begin
                check("a_out", {ol_a, od_a}, q_a.pop_front());
            end
        end
    end

    // ---------------- instance B: H=W=2, CIN=1, COUT=2 ----------------
    logic        start_b, busy_b, done_b, ifm_en_b, ker_en_b, ov_b, or_b, ol_b;
    logic [1:0]  ifm_addr_b;
    logic [4:0]  ker_addr_b;
    logic [15:0] ifm_data_b = '0, ker_data_b = '0, od_b;
    logic [15:0] ifm_mem_b [4];
    logic [15:0] ker_mem_b [18];
    logic [16:0] q_b [$];
    int          rd_ifm_b = 0, hs_b = 0, done_cnt_b = 0;

    conv3x3_relu_engine #(.H(2), .W(2), .CIN(1), .COUT(2), .DATA_W(16), .FRAC_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .ifm_rd_en(ifm_en_b), .ifm_rd_addr(ifm_addr_b), .ifm_rd_data(ifm_data_b),
        .ker_rd_en(ker_en_b), .ker_rd_addr(ker_addr_b), .ker_rd_data(ker_data_b),
`ifdef CONV_BIAS_EN
        .bias_rd_en(bias_en_b), .bias_rd_addr(bias_addr_b), .bias_rd_data(bias_data_b),
`endif
        .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .out_last(ol_b)
    );

    always @(posedge clk) begin
        if (ifm_en_b) begin
            ifm_data_b <= ifm_mem_b[ifm_addr_b];
            rd_ifm_b++;
        end
        if (ker_en_b) ker_data_b <= ker_mem_b[ker_addr_b];
    end

    always @(negedge clk) begin
        if (done_b) done_cnt_b++;
        if (ov_b && or_b) begin
            hs_b++;
            if (q_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected_output: got %0h, expected none", od_b);
            end else begin
                check("b_out", {ol_b, od_b}, q_b.pop_front());
            end
        end
    end

    // ---------------- expected tables ----------------
    logic [15:0] exp_ones  [9] = '{16'h0400, 16'h0600, 16'h0400, 16'h0600, 16'h0900,
                                   16'h0600, 16'h0400, 16'h0600, 16'h0400};
    logic [15:0] exp_zero  [9] = '{9{16'h0000}};
    logic [15:0] exp_sat   [9] = '{9{16'h7FFF}};
    logic [15:0] exp_trunc [9] = '{16'h0002, 16'h0003, 16'h0002, 16'h0003, 16'h0004,
                                   16'h0003, 16'h0002, 16'h0003, 16'h0002};
    // B: co0 kernel = centre only, co1 kernel = top neighbour only
    logic [15:0] exp_b     [8] = '{16'h0100, 16'h0000, 16'h0200, 16'h0000,
                                   16'h0300, 16'h0100, 16'h0400, 16'h0200};

    task automatic run_a(input logic [15:0] dv, input logic [15:0] wv,
                         input logic [15:0] ex [9], input bit poke);
        int cyc;
        for (int i = 0; i < 9; i++) begin
            ifm_mem_a[i] = dv;
            ker_mem_a[i] = wv;
            q_a.push_back({(i == 8), ex[i]});
        end
        rd_ifm_a = 0;
        rd_ker_a = 0;
        bad_a = 0;
        done_cnt_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_busy_after_start", busy_a, 1);
        if (poke) begin
            repeat (3) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        cyc = 0;
        while (!done_a && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("a_done_seen", done_a, 1);
        if (poke) begin
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            check("a_start_in_fin_ignored", busy_a, 0);
        end
        repeat (3) @(negedge clk);
        check("a_busy_idle", busy_a, 0);
        check("a_done_once", done_cnt_a, 1);
        check("a_ifm_reads", rd_ifm_a, 49);
        check("a_ker_reads", rd_ker_a, 49);
        check("a_addr_range", bad_a, 0);
        check("a_queue_empty", q_a.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int lat;
        logic [15:0] held;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        or_a = 1'b1;
        or_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_out_valid", ov_a, 0);
        check("rst_rd_en", {ifm_en_a, ker_en_a}, 0);
        check("rst_out_data", od_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_a(16'h0100, 16'h0100, exp_ones, 1'b1);
        run_a(16'h0100, 16'hFF00, exp_zero, 1'b0);
        run_a(16'h7F00, 16'h7F00, exp_sat, 1'b0);
        run_a(16'h0001, 16'h0080, exp_trunc, 1'b0);

        // abort mid-MAC with an asynchronous reset
        done_cnt_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (!ifm_en_a && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reading_before_reset", ifm_en_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_rd_en", {ifm_en_a, ker_en_a}, 0);
        check("abort_addr", {ifm_addr_a, ker_addr_a}, 0);
        check("abort_out", {ov_a, ol_a, od_a}, 0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_a(16'h0100, 16'h0100, exp_ones, 1'b0);

        // instance B: latency, backpressure, channel interleave
        for (int i = 0; i < 4; i++) ifm_mem_b[i] = 16'h0100 * 16'(i + 1);
        for (int i = 0; i < 18; i++) ker_mem_b[i] = '0;
        ker_mem_b[4]  = 16'h0100;
        ker_mem_b[10] = 16'h0100;
        for (int i = 0; i < 8; i++) q_b.push_back({(i == 7), exp_b[i]});
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        lat = 1;
        while (!ov_b && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b_first_latency", lat, 13);
        @(negedge clk);
        held = od_b;
        check("b_first_data", held, 16'h0100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_stall_valid", ov_b, 1);
            check("b_stall_data", {ol_b, od_b}, {1'b0, held});
        end
        or_b = 1'b1;
        cyc = 0;
        while (!done_b && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("b_done_seen", done_b, 1);
        repeat (3) @(negedge clk);
        check("b_handshakes", hs_b, 8);
        check("b_done_once", done_cnt_b, 1);
        check("b_ifm_reads", rd_ifm_b, 32);
        check("b_queue_empty", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
